regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port (write_en/rsW/write_data) between the
//  in-order pipeline writeback stage and a long-latency unit (mul/div, MDU).
//  MDU results are buffered in a small FIFO. The pipeline has priority, with an

---
 rtl/regfile_arb_pkg.sv | 17 +
 rtl/regfile_wb_arbiter_wb_fifo.sv | 86 ++++++++
 rtl/regfile_wb_arbiter.sv | 146 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_arb_pkg;

    localparam int REGF_WIDTH = 32;
    localparam int REG_COUNT  = 32;

    typedef enum logic {
        ARB_NORMAL = 1'b0,
        ARB_FORCE  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [4:0]            rd;
        logic [REGF_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// wb_fifo: synchronous FIFO of MDU writeback requests (rd + data).
// Pointers carry one extra wrap bit so full/empty need no separate counter.
// Optional macro WBARB_PENDING_MASK_EN builds a per-register "write buffered"
// mask from the live entries; without it the mask output is tied low.
module wb_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [4:0]        push_rd_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [4:0]        head_rd_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [31:0]       pending_mask_o
);
    import regfile_arb_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [4:0]        rd_mem_q   [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // The head is read from storage, so a fresh push is never visible the same cycle.
    assign head_rd_o   = rd_mem_q[rd_ptr_q[AW-1:0]];
    assign head_data_o = data_mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer values from accepted push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers; reset empties the FIFO and discards its contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage, written on an accepted push only.
    always_ff @(posedge clk) begin
        if (do_push) begin
            rd_mem_q[wr_ptr_q[AW-1:0]]   <= push_rd_i;
            data_mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

`ifdef WBARB_PENDING_MASK_EN
    logic [AW:0] count;
    assign count = wr_ptr_q - rd_ptr_q;

    // Mark every register targeted by a live entry; x0 is never pending.
    always_comb begin
        pending_mask_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((AW+1)'(i) < count)
                pending_mask_o[rd_mem_q[rd_ptr_q[AW-1:0] + AW'(i)]] = 1'b1;
        end
        pending_mask_o[0] = 1'b0;
    end
`else
    assign pending_mask_o = {REG_COUNT{1'b0}};
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between the
// pipeline writeback stage and an MDU whose results queue in wb_fifo.
// The pipeline has priority; after STARVE_LIMIT consecutive losses by a
// non-empty FIFO head, one cycle is forced for the MDU (pipeline stalled).
// All register-file outputs are registered (one-cycle latency).
// Valid/ready: a transfer happens on a cycle where valid and ready are both 1.
// Optional macro: WBARB_PENDING_MASK_EN enables pending_mask decode.
module regfile_wb_arbiter #(
    parameter int REGF_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_wb_valid,
    input  logic [4:0]            pipe_wb_rd,
    input  logic [REGF_WIDTH-1:0] pipe_wb_data,
    output logic                  pipe_wb_ready,
    input  logic                  mdu_valid,
    input  logic [4:0]            mdu_rd,
    input  logic [REGF_WIDTH-1:0] mdu_data,
    output logic                  mdu_ready,
    output logic                  write_en,
    output logic [4:0]            rsW,
    output logic [REGF_WIDTH-1:0] write_data,
    output logic [31:0]           pending_mask
);
    import regfile_arb_pkg::*;

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    arb_state_t            state_q, state_d;
    logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
    logic                  fifo_pop;
    logic [4:0]            head_rd;
    logic [REGF_WIDTH-1:0] head_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  grant;
    logic [4:0]            grant_rd;
    logic [REGF_WIDTH-1:0] grant_data;
    logic                  write_en_q, write_en_d;
    logic [4:0]            rsw_q, rsw_d;
    logic [REGF_WIDTH-1:0] write_data_q, write_data_d;

    assign mdu_ready = !fifo_full;

    wb_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (REGF_WIDTH)
    ) u_fifo (
        .clk            (clk),
        .rst            (rst),
        .push_i         (mdu_valid),
        .push_rd_i      (mdu_rd),
        .push_data_i    (mdu_data),
        .pop_i          (fifo_pop),
        .head_rd_o      (head_rd),
        .head_data_o    (head_data),
        .full_o         (fifo_full),
        .empty_o        (fifo_empty),
        .pending_mask_o (pending_mask)
    );

    // Arbitration: pick the winner, count head losses, schedule the forced cycle.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        pipe_wb_ready = 1'b0;
        fifo_pop      = 1'b0;
        grant         = 1'b0;
        grant_rd      = pipe_wb_rd;
        grant_data    = pipe_wb_data;
        case (state_q)
            ARB_NORMAL: begin
                pipe_wb_ready = 1'b1;
                if (pipe_wb_valid) begin
                    grant = 1'b1;
                    if (!fifo_empty) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                        if (wait_cnt_d == CW'(STARVE_LIMIT)) state_d = ARB_FORCE;
                    end else begin
                        wait_cnt_d = '0;
                    end
                end else if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    grant      = 1'b1;
                    grant_rd   = head_rd;
                    grant_data = head_data;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = '0;
                end
            end
            ARB_FORCE: begin
                // Entered only with a non-empty FIFO that has not popped since.
                fifo_pop   = 1'b1;
                grant      = 1'b1;
                grant_rd   = head_rd;
                grant_data = head_data;
                wait_cnt_d = '0;
                state_d    = ARB_NORMAL;
            end
            default: begin
                state_d    = ARB_NORMAL;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Output stage inputs: x0 writes are consumed but never raise write_en.
    always_comb begin
        write_en_d   = grant && (grant_rd != 5'd0);
        rsw_d        = write_en_d ? grant_rd : rsw_q;
        write_data_d = write_en_d ? grant_data : write_data_q;
    end

    // FSM state and starvation counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_NORMAL;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Registered register-file write port; reset drops any in-flight write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_en_q   <= 1'b0;
            rsw_q        <= '0;
            write_data_q <= '0;
        end else begin
            write_en_q   <= write_en_d;
            rsw_q        <= rsw_d;
            write_data_q <= write_data_d;
        end
    end

    assign write_en   = write_en_q;
    assign rsW        = rsw_q;
    assign write_data = write_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios plus randomized traffic,
// checked against a queue-based model; register-file writes go through a
// scoreboard whose entries carry the cycle they are due on.
module tb_regfile_wb_arbiter;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int LIMIT = 3;
    localparam int EW    = 16 + 5 + W;

    logic         clk = 1'b0;
    logic         rst;
    logic         pipe_wb_valid;
    logic [4:0]   pipe_wb_rd;
    logic [W-1:0] pipe_wb_data;
    logic         pipe_wb_ready;
    logic         mdu_valid;
    logic [4:0]   mdu_rd;
    logic [W-1:0] mdu_data;
    logic         mdu_ready;
    logic         write_en;
    logic [4:0]   rsW;
    logic [W-1:0] write_data;
    logic [31:0]  pending_mask;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .REGF_WIDTH   (W),
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pipe_wb_valid (pipe_wb_valid),
        .pipe_wb_rd    (pipe_wb_rd),
        .pipe_wb_data  (pipe_wb_data),
        .pipe_wb_ready (pipe_wb_ready),
        .mdu_valid     (mdu_valid),
        .mdu_rd        (mdu_rd),
        .mdu_data      (mdu_data),
        .mdu_ready     (mdu_ready),
        .write_en      (write_en),
        .rsW           (rsW),
        .write_data    (write_data),
        .pending_mask  (pending_mask)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard / model state ----------------
    logic [EW-1:0]  exp_q[$];   // {due_cycle[15:0], rd, data}
    logic [5+W-1:0] mq[$];      // model of buffered MDU results, head first
    bit             force_m;    // next cycle belongs to the MDU
    int             wcnt;       // consecutive cycles the head has lost
    bit             pipe_hold;
    bit             mdu_hold;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = '0;
        foreach (mq[i]) m[mq[i][W+4:W]] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        force_m   = 0;
        wcnt      = 0;
        pipe_hold = 0;
        mdu_hold  = 0;
        pipe_wb_valid = 0; pipe_wb_rd = '0; pipe_wb_data = '0;
        mdu_valid     = 0; mdu_rd     = '0; mdu_data     = '0;
    endtask

    // ---------------- driver ----------------
    // Offers new values unless a previous offer is still waiting for ready.
    task automatic drive_cycle(input bit pv, input logic [4:0] prd, input logic [W-1:0] pd,
                               input bit mv, input logic [4:0] mrd, input logic [W-1:0] md);
        bit             exp_ready;
        bit             full_m;
        bit             got;
        logic [5+W-1:0] g;
        @(negedge clk);
        if (!pipe_hold) begin pipe_wb_valid = pv; pipe_wb_rd = prd; pipe_wb_data = pd; end
        if (!mdu_hold)  begin mdu_valid = mv; mdu_rd = mrd; mdu_data = md; end
        #1;
        exp_ready = !force_m;
        full_m    = (mq.size() == DEPTH);
        check("pipe_wb_ready", 64'(pipe_wb_ready), 64'(exp_ready));
        check("mdu_ready", 64'(mdu_ready), 64'(!full_m));
`ifdef WBARB_PENDING_MASK_EN
        check("pending_mask", 64'(pending_mask), 64'(model_mask()));
`else
        check("pending_mask", 64'(pending_mask), 64'h0);
`endif
        got = 0;
        g   = '0;
        if (force_m) begin
            g = mq.pop_front(); got = 1; force_m = 0; wcnt = 0;
        end else if (pipe_wb_valid) begin
            g = {pipe_wb_rd, pipe_wb_data}; got = 1;
            if (mq.size() > 0) begin
                wcnt++;
                if (wcnt == LIMIT) force_m = 1;
            end
        end else if (mq.size() > 0) begin
            g = mq.pop_front(); got = 1; wcnt = 0;
        end
        if (mdu_valid && !full_m) mq.push_back({mdu_rd, mdu_data});
        if (got && g[W+4:W] != 5'd0) exp_q.push_back({16'(cyc + 1), g});
        pipe_hold = pipe_wb_valid && !exp_ready;
        mdu_hold  = mdu_valid && full_m;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 5'd0, '0, 0, 5'd0, '0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst) begin
            if (write_en) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_write: got rsW=%0d data=%0h, expected no write (cycle %0d)",
                             rsW, write_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("write_cycle", 64'(cyc), 64'(e[EW-1 -: 16]));
                    check("rsW", 64'(rsW), 64'(e[W+4:W]));
                    check("write_data", 64'(write_data), 64'(e[W-1:0]));
                end
            end else if (exp_q.size() > 0 && exp_q[0][EW-1 -: 16] == 16'(cyc)) begin
                tests++; fails++;
                $display("FAIL missing_write: got write_en=0, expected rd=%0d data=%0h (cycle %0d)",
                         exp_q[0][W+4:W], exp_q[0][W-1:0], cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        model_reset();
        #3;
        check("reset_write_en", 64'(write_en), 64'h0);
        check("reset_rsW", 64'(rsW), 64'h0);
        check("reset_write_data", 64'(write_data), 64'h0);
        check("reset_mdu_ready", 64'(mdu_ready), 64'h1);
        check("reset_pipe_ready", 64'(pipe_wb_ready), 64'h1);
        check("reset_pending_mask", 64'(pending_mask), 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // pipeline only
        drive_cycle(1, 5'd5, 32'd12345, 0, 5'd0, '0);
        idle(2);

        // x0 writes from both sources are consumed silently
        drive_cycle(1, 5'd0, 32'hDEADBEEF, 0, 5'd0, '0);
        drive_cycle(0, 5'd0, '0, 1, 5'd0, 32'h1111);
        idle(3);

        // starvation: head loses LIMIT cycles then is forced through
        drive_cycle(0, 5'd0, '0, 1, 5'd10, 32'd54321);
        for (int i = 0; i < 6; i++) drive_cycle(1, 5'(i + 1), 32'(100 + i), 0, 5'd0, '0);
        idle(3);

        // fill the FIFO while the pipeline is busy; the 5th offer waits
        for (int i = 0; i < 5; i++)
            drive_cycle(1, 5'(20 + i), 32'(200 + i), 1, 5'(11 + i), $urandom);
        for (int i = 0; i < 6; i++) drive_cycle(1, 5'(25 + i), 32'(300 + i), 0, 5'd0, '0);
        idle(8);

        // pending mask for a single buffered rd=7 write
        drive_cycle(1, 5'd3, 32'd33, 1, 5'd7, 32'd777);
        idle(3);

        // reset with a write in flight and results buffered
        drive_cycle(1, 5'd9, 32'h99, 1, 5'd12, 32'h1212);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_write_en", 64'(write_en), 64'h0);
        check("midrst_rsW", 64'(rsW), 64'h0);
        check("midrst_mdu_ready", 64'(mdu_ready), 64'h1);
        check("midrst_pending_mask", 64'(pending_mask), 64'h0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(3);

        // randomized traffic
        for (int i = 0; i < 600; i++)
            drive_cycle($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
                        $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), $urandom);
        idle(20);
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
